divider: RTL and testbench

DIVIDER -- requirements
Module: divider

---
 rtl/divider.sv | 84 ++++++++
 tb/tb_divider.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/divider.sv
// divider: sequential unsigned restoring divider, one quotient bit per cycle, MSB first.
// Results are registered on entry to DONE; the done pulse follows one cycle later.
module divider #(
  parameter int DIVIDEND_WIDTH = 32,
  parameter int DIVISOR_WIDTH  = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [DIVIDEND_WIDTH-1:0] dividend,
  input  logic [DIVISOR_WIDTH-1:0]  divisor,
  output logic                      busy,
  output logic                      done,
  output logic [DIVIDEND_WIDTH-1:0] quotient,
  output logic [DIVISOR_WIDTH-1:0]  remainder,
  output logic                      div_by_zero
);
  localparam int CW = $clog2(DIVIDEND_WIDTH + 1);
  localparam int RW = DIVISOR_WIDTH + 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t                    r_state;
  logic [CW-1:0]             r_cnt;
  logic [DIVIDEND_WIDTH-1:0] r_dvd;
  logic [DIVISOR_WIDTH-1:0]  r_dvs;
  logic [RW-1:0]             r_rem;
  logic                      r_done;
  logic [RW:0]               w_shift, w_diff, w_next;
  logic                      w_ge;
  // dividend register doubles as the quotient shift register
  assign w_shift = {r_rem, r_dvd[DIVIDEND_WIDTH-1]};
  assign w_ge    = w_shift >= (RW+1)'(r_dvs);
  assign w_diff  = w_shift - (RW+1)'(r_dvs);
  assign w_next  = w_ge ? w_diff : w_shift;
  assign done    = r_done;
  // the done cycle still counts as busy so a held start cannot slip in
  assign busy    = (r_state != IDLE) || r_done;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_dvd       <= '0;
      r_dvs       <= '0;
      r_rem       <= '0;
      r_done      <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: if (start && !r_done) begin
          r_dvd <= dividend;
          if (divisor == '0) begin
            quotient    <= '1;
            remainder   <= dividend[DIVISOR_WIDTH-1:0];
            div_by_zero <= 1'b1;
            r_state     <= DONE;
          end else begin
            r_dvs   <= divisor;
            r_rem   <= '0;
            r_cnt   <= CW'(DIVIDEND_WIDTH);
            r_state <= RUN;
          end
        end
        RUN: begin
          r_rem <= RW'(w_next);
          r_dvd <= {r_dvd[DIVIDEND_WIDTH-2:0], w_ge};
          r_cnt <= r_cnt - CW'(1);
          if (r_cnt == CW'(1)) begin
            quotient    <= {r_dvd[DIVIDEND_WIDTH-2:0], w_ge};
            remainder   <= DIVISOR_WIDTH'(w_next);
            div_by_zero <= 1'b0;
            r_state     <= DONE;
          end
        end
        DONE: begin
          r_done  <= 1'b1;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_divider.sv
// tb_divider: randomized self-checking bench for divider against an arithmetic reference.
module tb_divider;
  logic        clk = 1'b0;
  logic        rst, start, busy, done, div_by_zero;
  logic [31:0] dividend, quotient;
  logic [15:0] divisor, remainder;
  int errs = 0;
  int checks = 0;

  divider dut (
    .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic run_op(input logic [31:0] a, input logic [15:0] b,
                        output logic [31:0] q, output logic [15:0] r,
                        output logic z, output int lat);
    int g = 0;
    @(negedge clk);
    while ((busy || done) && g < 100) begin
      @(negedge clk);
      g++;
    end
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b0;
    dividend = $urandom;
    divisor  = 16'($urandom);
    lat = -1;
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = k;
        break;
      end
    end
    q = quotient;
    r = remainder;
    z = div_by_zero;
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b1; dividend = 32'd1554; divisor = 16'd42;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, div_by_zero} !== 3'b000 || quotient !== 32'd0 || remainder !== 16'd0) begin
      errs++;
      $display("FAIL reset_state: busy=%b done=%b dbz=%b q=%h r=%h, required all 0",
               busy, done, div_by_zero, quotient, remainder);
    end
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
  endtask

  task automatic test_vectors;
    logic [31:0] ta[5] = '{32'd1554, 32'd1555, 32'hFFFF_FFFF, 32'h1234_5678, 32'd7};
    logic [15:0] tb[5] = '{16'd42, 16'd42, 16'hFFFF, 16'd0, 16'd9};
    logic [31:0] eq[5] = '{32'd37, 32'd37, 32'h0001_0001, 32'hFFFF_FFFF, 32'd0};
    logic [15:0] er[5] = '{16'd0, 16'd1, 16'd0, 16'h5678, 16'd7};
    logic [31:0] q;
    logic [15:0] r;
    logic z;
    int lat;
    for (int i = 0; i < 5; i++) begin
      run_op(ta[i], tb[i], q, r, z, lat);
      checks++;
      if (lat !== ((tb[i] == 0) ? 1 : 33)) begin
        errs++;
        $display("FAIL vec%0d_latency: got %0d required %0d", i, lat, (tb[i] == 0) ? 1 : 33);
      end
      checks++;
      if (q !== eq[i] || r !== er[i] || z !== (tb[i] == 0)) begin
        errs++;
        $display("FAIL vec%0d_result: q=%h r=%h dbz=%b required q=%h r=%h dbz=%b",
                 i, q, r, z, eq[i], er[i], tb[i] == 0);
      end
      @(posedge clk);
      #1;
      checks++;
      if (done !== 1'b0) begin
        errs++;
        $display("FAIL vec%0d_done_width: done=%b required 0", i, done);
      end
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (quotient !== eq[i] || remainder !== er[i] || busy !== 1'b0) begin
        errs++;
        $display("FAIL vec%0d_hold: q=%h r=%h busy=%b required q=%h r=%h busy=0",
                 i, quotient, remainder, busy, eq[i], er[i]);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] bd[150];
    logic [15:0] bs[150];
    logic [31:0] xq;
    logic [15:0] xr;
    int acc = 0;
    int len;
    int ndone = 0;
    for (int i = 0; i < 150; i++) begin
      bd[i] = $urandom;
      bs[i] = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom_range(1, 65535));
    end
    len = (bs[0] == 0) ? 1 : 33;
    for (int e = 0; e < 150; e++) begin
      @(negedge clk);
      dividend = bd[e]; divisor = bs[e]; start = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if (done !== (e == acc + len)) begin
        errs++;
        $display("FAIL b2b_done_e%0d: done=%b required %b", e, done, e == acc + len);
      end
      if (e == acc + len) begin
        ndone++;
        xq = (bs[acc] == 0) ? 32'hFFFF_FFFF : bd[acc] / bs[acc];
        xr = (bs[acc] == 0) ? bd[acc][15:0] : 16'(bd[acc] % bs[acc]);
        checks++;
        if (quotient !== xq || remainder !== xr || div_by_zero !== (bs[acc] == 0)) begin
          errs++;
          $display("FAIL b2b_result_e%0d: q=%h r=%h dbz=%b required q=%h r=%h dbz=%b",
                   e, quotient, remainder, div_by_zero, xq, xr, bs[acc] == 0);
        end
      end
      if (e >= acc && e < acc + len) begin
        checks++;
        if (busy !== 1'b1) begin
          errs++;
          $display("FAIL b2b_busy_e%0d: busy=%b required 1", e, busy);
        end
      end
      if (e == acc + len + 1) begin
        checks++;
        if (busy !== 1'b0) begin
          errs++;
          $display("FAIL b2b_idle_e%0d: busy=%b required 0", e, busy);
        end
        acc = e + 1;
        len = (acc < 150) ? ((bs[acc] == 0) ? 1 : 33) : 1000;
      end
    end
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (ndone < 3) begin
      errs++;
      $display("FAIL b2b_count: %0d results seen, required at least 3", ndone);
    end
  endtask

  task automatic test_reset_mid_run;
    logic [31:0] q;
    logic [15:0] r;
    logic z;
    int lat;
    int seen = 0;
    @(negedge clk);
    dividend = 32'd1554; divisor = 16'd42; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst = 1'b1; start = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0; start = 1'b0;
    checks++;
    if ({busy, done, div_by_zero} !== 3'b000 || quotient !== 32'd0 || remainder !== 16'd0) begin
      errs++;
      $display("FAIL abort_clear: busy=%b done=%b dbz=%b q=%h r=%h, required all 0",
               busy, done, div_by_zero, quotient, remainder);
    end
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      if (done) seen++;
    end
    checks++;
    if (seen != 0) begin
      errs++;
      $display("FAIL abort_no_done: %0d done pulses, required 0", seen);
    end
    run_op(32'd100, 16'd7, q, r, z, lat);
    checks++;
    if (q !== 32'd14 || r !== 16'd2 || z !== 1'b0 || lat != 33) begin
      errs++;
      $display("FAIL after_abort: q=%0d r=%0d dbz=%b lat=%0d required q=14 r=2 dbz=0 lat=33",
               q, r, z, lat);
    end
  endtask

  task automatic test_random;
    logic [31:0] a, q;
    logic [15:0] b, r;
    logic z;
    int lat;
    longint unsigned recon;
    for (int i = 0; i < 1000; i++) begin
      a = ($urandom_range(0, 7) == 0) ? 32'($urandom_range(0, 300)) : $urandom;
      b = ($urandom_range(0, 7) == 0) ? 16'($urandom_range(1, 5)) : 16'($urandom_range(1, 65535));
      run_op(a, b, q, r, z, lat);
      recon = longint'(q) * longint'(b) + longint'(r);
      checks++;
      if (recon != longint'(a) || r >= b || z !== 1'b0 || lat != 33) begin
        errs++;
        $display("FAIL rand%0d: %h/%h gave q=%h r=%h dbz=%b lat=%0d required q=%h r=%h dbz=0 lat=33",
                 i, a, b, q, r, z, lat, a / b, 16'(a % b));
      end
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    test_reset;
    test_vectors;
    test_back_to_back;
    test_reset_mid_run;
    test_random;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
